// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline-control types and constants
package riscv_pipe_pkg;

  localparam int REG_AD_W = 5;

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_STALL = 1'b1;

  // Enables and flushes for the PC and the four pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic if_dec_en;
    logic if_dec_flush;
    logic dec_ex_en;
    logic dec_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - load-use stall, memory freeze and branch flush control
module hazard_stall_unit
  import riscv_pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AD_W-1:0] if_dec_rs1_ad,
  input  logic [REG_AD_W-1:0] if_dec_rs2_ad,
  input  logic                if_dec_rs1_used,
  input  logic                if_dec_rs2_used,
  input  logic [REG_AD_W-1:0] dec_ex_rd_ad,
  input  logic                dec_ex_memRead,
  input  logic                ex_branch_taken,
  input  logic                mem_busy,
  input  logic                perf_clr,
  output logic                pc_en,
  output logic                if_dec_en,
  output logic                if_dec_flush,
  output logic                dec_ex_en,
  output logic                dec_ex_flush,
  output logic                ex_mem_en,
  output logic                mem_wb_flush,
  output logic [CNT_W-1:0]    stall_count,
  output logic [CNT_W-1:0]    flush_count,
  output logic [CNT_W-1:0]    freeze_count
);

  localparam logic [2:0] BCNT_LOAD = 3'(LOAD_LAT - 1);

  logic       state, state_nxt;
  logic [2:0] bcnt, bcnt_nxt;
  logic       load_use;
  pipe_ctrl_t ctrl;

  assign load_use = dec_ex_memRead && (dec_ex_rd_ad != '0) &&
                    ((if_dec_rs1_used && (if_dec_rs1_ad == dec_ex_rd_ad)) ||
                     (if_dec_rs2_used && (if_dec_rs2_ad == dec_ex_rd_ad)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      bcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      bcnt  <= bcnt_nxt;
    end
  end

  // A memory wait freezes the FSM so the remaining bubble count survives it.
  always_comb begin
    state_nxt = state;
    bcnt_nxt  = bcnt;
    if (mem_busy) begin
      state_nxt = state;
    end else if (ex_branch_taken) begin
      state_nxt = ST_RUN;
      bcnt_nxt  = 3'd0;
    end else if (state == ST_STALL) begin
      bcnt_nxt = bcnt - 3'd1;
      if (bcnt == 3'd1) state_nxt = ST_RUN;
    end else if (load_use && (LOAD_LAT > 1)) begin
      state_nxt = ST_STALL;
      bcnt_nxt  = BCNT_LOAD;
    end
  end

  always_comb begin
    ctrl = CTRL_RUN;
    if (rst)                                  ctrl = CTRL_RESET;
    else if (mem_busy)                        ctrl = CTRL_FREEZE;
    else if (ex_branch_taken)                 ctrl = CTRL_BRANCH;
    else if ((state == ST_STALL) || load_use) ctrl = CTRL_STALL;
  end

  assign pc_en        = ctrl.pc_en;
  assign if_dec_en    = ctrl.if_dec_en;
  assign if_dec_flush = ctrl.if_dec_flush;
  assign dec_ex_en    = ctrl.dec_ex_en;
  assign dec_ex_flush = ctrl.dec_ex_flush;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_flush = ctrl.mem_wb_flush;

  logic stall_inc, flush_inc, freeze_inc;
  assign freeze_inc = mem_busy;
  assign flush_inc  = !mem_busy && ex_branch_taken;
  assign stall_inc  = !mem_busy && !ex_branch_taken && ((state == ST_STALL) || load_use);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(stall_inc), .q(stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(flush_inc), .q(flush_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk(clk), .rst(rst), .clr(perf_clr), .inc(freeze_inc), .q(freeze_count)
  );

endmodule
